saikoro_reader: RTL and testbench
=================================

# saikoro_reader

Receive-side counterpart of the saikoro die: samples the 7-lamp pip bus, debounces it, decodes each stable pip pattern back to a face value 1..6, and delivers it over a valid/ready handshake. Sits at the consumer end of the lamp interface, for example in a scoreboard or a second board watching a die. It flags malformed patterns. Optionally it keeps a per-face roll histogram.

## Interface
- STABLE_CYCLES, default 4: number of consecutive sampled cycles a pattern must hold before it is accepted; legal range 1..255.
- CNT_W, default 8: width of each histogram counter.

Ports:
- ck  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- lamp  in  7  pip pattern from a die, bit 6 = MSB.
- out_value  out  3  decoded face, 1..6.
- out_valid  out  1  out_value holds an undelivered face.
- out_ready  in  1  consumer accepts out_value this cycle when out_valid=1.
- err  out  1  one-cycle pulse when a stable pattern is not a legal face or blank.
- ovf  out  1  sticky; a face was dropped because the output register was full.
- hist_sel  in  3  face selector for histogram readout.
- hist_count  out  CNT_W  roll count for face hist_sel.

## Operation
- Legal patterns:
  - 1=0001000, 2=1000001, 3=0011100, 4=1010101, 5=1011101, 6=1110111.
  - 0000000 = blank; it is accepted silently and is not an error.
  - Every other pattern is illegal.
- Input register lamp_q samples lamp every cycle. All decisions use lamp_q only.
- FSM states: IDLE, QUAL, WAIT_CHG.
  - IDLE: go to QUAL when lamp_q != cand, loading cand=lamp_q and stab=1.
  - QUAL: if lamp_q==cand, stab increments. When stab reaches STABLE_CYCLES, the pattern is accepted and the FSM goes to WAIT_CHG. If lamp_q!=cand, reload cand=lamp_q, set stab=1, and stay in QUAL (glitch restart).
  - WAIT_CHG: stay until lamp_q!=cand, then go to QUAL with the new cand and stab=1.
- Acceptance produces exactly one event per distinct stable pattern:
  - Legal face: the face is offered to the output register.
  - Blank: no output.
  - Illegal: err=1 for that one cycle.
- Two identical consecutive rolls are indistinguishable unless a different pattern (e.g. blank) appears between them.
- Output register, single entry:
  - A face is loaded if out_valid=0, or if out_valid&&out_ready in the same cycle (pop and load together: out_valid stays 1, no ovf).
  - Otherwise the new face is dropped and ovf is set. ovf clears only on reset.
  - out_valid&&out_ready with no acceptance clears out_valid.
- Histogram: counter[f] increments on every accepted legal face f, including dropped ones, and saturates at 2^CNT_W-1. hist_count = counter[hist_sel], combinational. hist_sel of 0 or 7 reads 0.

## Timing
- Reset values:
  - out_valid=0, out_value=0, err=0, ovf=0.
  - All histogram counters 0.
  - lamp_q=0000000, cand=0000000, stab=0.
  - FSM in IDLE.
- Reset mid-qualification aborts it. A pattern held through reset is requalified from scratch after reset drops, since lamp_q restarts at blank.
- Latency: a new pattern held on lamp from edge E0 is accepted at edge E0+STABLE_CYCLES. out_valid/err are high in the following cycle, i.e. observed STABLE_CYCLES+1 edges after first presentation.
- STABLE_CYCLES=1: acceptance at the edge after lamp_q first shows the pattern.
- stab width is 8 bits; it never counts past STABLE_CYCLES.
- Handshake: out_value is stable while out_valid=1 and out_ready=0.

## Configuration
- SAIKORO_READER_HIST_EN defined: histogram counters and hist_count readout are present, as described above.
- SAIKORO_READER_HIST_EN undefined: no counters are instantiated, hist_count is tied to 0, and hist_sel is ignored. All other behaviour is identical.

## Structure
- Shared package saikoro_pkg holds:
  - Face pattern constants LAMP_F1..LAMP_F6 and LAMP_BLANK.
  - Face value width constant (3).
  - FSM state typedef.
- The die and the reader both use saikoro_pkg, so the encoding has one source.
- One sub-module, saikoro_lamp_dec: combinational; maps 7-bit pattern to {value[2:0], is_face, is_blank}.

## Test plan
- STABLE_CYCLES=4, out_ready=1, lamp=1010101 held from E0 -> out_valid=1 with out_value=4 for one cycle after edge E4; err=0; hist_count(sel=4)=1.
- lamp toggles between 1011101 and 1110111 every 2 cycles for 20 cycles -> no out_valid, no err. Then 1110111 held -> out_value=6 once.
- lamp=0110000 held 6 cycles -> err pulses once, for exactly 1 cycle; out_valid stays 0; histogram unchanged.
- out_ready=0; faces 2, blank, 3 each held 6 cycles -> out_value=2 retained, ovf=1 after 3 is accepted. Then out_ready=1 -> 2 delivered, out_valid=0. hist(2)=1, hist(3)=1.
- Face 5 accepted in the same cycle as out_valid&&out_ready for face 1 -> out_value=5, out_valid stays 1, ovf=0.
- reset asserted at stab=2 while lamp=0001000, then released -> no output until 4 further stable cycles, then out_value=1. With CNT_W=2, four face-1 rolls separated by blanks -> hist(1) saturates at 3.

Source files
------------

// File: rtl/saikoro_pkg.sv
// Shared lamp encoding for the saikoro die and its reader.
// Face patterns, face value width and reader FSM state type.
package saikoro_pkg;

    localparam int FACE_W = 3;

    localparam logic [6:0] LAMP_BLANK = 7'b0000000;
    localparam logic [6:0] LAMP_F1    = 7'b0001000;
    localparam logic [6:0] LAMP_F2    = 7'b1000001;
    localparam logic [6:0] LAMP_F3    = 7'b0011100;
    localparam logic [6:0] LAMP_F4    = 7'b1010101;
    localparam logic [6:0] LAMP_F5    = 7'b1011101;
    localparam logic [6:0] LAMP_F6    = 7'b1110111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUAL,
        ST_WAIT_CHG
    } rd_state_e;

endpackage

// File: rtl/saikoro_reader_if.sv
// Decoded-face valid/ready channel of the saikoro reader.
// master drives the face, slave is the consumer.
interface saikoro_reader_if;
    import saikoro_pkg::*;

    logic [FACE_W-1:0] out_value;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_value,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_value,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/saikoro_lamp_dec.sv
// Combinational pip-pattern decoder: 7-bit lamp to face value.
// value is 0 unless is_face; blank is reported separately.
module saikoro_lamp_dec
    import saikoro_pkg::*;
(
    input  logic [6:0]        lamp_i,
    output logic [FACE_W-1:0] value_o,
    output logic              is_face_o,
    output logic              is_blank_o
);

    always_comb begin
        value_o    = '0;
        is_face_o  = 1'b1;
        is_blank_o = 1'b0;
        case (lamp_i)
            LAMP_F1:    value_o = 3'd1;
            LAMP_F2:    value_o = 3'd2;
            LAMP_F3:    value_o = 3'd3;
            LAMP_F4:    value_o = 3'd4;
            LAMP_F5:    value_o = 3'd5;
            LAMP_F6:    value_o = 3'd6;
            LAMP_BLANK: begin
                is_face_o  = 1'b0;
                is_blank_o = 1'b1;
            end
            default:    is_face_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/saikoro_reader.sv
// Saikoro lamp reader: debounce, decode, single-entry valid/ready output.
// Define SAIKORO_READER_HIST_EN to build the per-face roll histogram.
module saikoro_reader
    import saikoro_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             ck,
    input  logic             reset,
    input  logic [6:0]       lamp,
    saikoro_reader_if.master out_if,
    output logic             err,
    output logic             ovf,
    input  logic [2:0]       hist_sel,
    output logic [CNT_W-1:0] hist_count
);

    localparam logic [7:0] STAB_TGT = 8'(STABLE_CYCLES);

    rd_state_e         state_q, state_d;
    logic [6:0]        lamp_q;
    logic [6:0]        cand_q, cand_d;
    logic [7:0]        stab_q, stab_d;
    logic [FACE_W-1:0] val_q, val_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic              acc;
    logic              pop;
    logic [FACE_W-1:0] dec_val;
    logic              dec_face;
    logic              dec_blank;

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lamp_q  <= LAMP_BLANK;
            cand_q  <= LAMP_BLANK;
            stab_q  <= '0;
            val_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lamp_q  <= lamp;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            val_q   <= val_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // Any change restarts qualification; with a target of 1 it accepts at once.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        stab_d  = stab_q;
        acc     = 1'b0;
        if (lamp_q != cand_q) begin
            cand_d = lamp_q;
            stab_d = 8'd1;
            if (STAB_TGT == 8'd1) begin
                acc     = 1'b1;
                state_d = ST_WAIT_CHG;
            end else begin
                state_d = ST_QUAL;
            end
        end else if (state_q == ST_QUAL) begin
            if (stab_q + 8'd1 >= STAB_TGT) begin
                stab_d  = STAB_TGT;
                acc     = 1'b1;
                state_d = ST_WAIT_CHG;
            end else begin
                stab_d = stab_q + 8'd1;
            end
        end
    end

    saikoro_lamp_dec u_dec (
        .lamp_i     (cand_d),
        .value_o    (dec_val),
        .is_face_o  (dec_face),
        .is_blank_o (dec_blank)
    );

    assign pop = vld_q && out_if.out_ready;

    always_comb begin
        val_d = val_q;
        vld_d = vld_q;
        ovf_d = ovf_q;
        err_d = acc && !dec_face && !dec_blank;
        if (acc && dec_face) begin
            if (!vld_q || pop) begin
                val_d = dec_val;
                vld_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop) begin
            vld_d = 1'b0;
        end
    end

    assign out_if.out_value = val_q;
    assign out_if.out_valid = vld_q;
    assign err              = err_q;
    assign ovf              = ovf_q;

`ifdef SAIKORO_READER_HIST_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [6];
    logic [2:0]       cnt_idx;

    assign cnt_idx = dec_val - 3'd1;

    // Dropped faces still count: the histogram tracks rolls, not deliveries.
    always_ff @(posedge ck) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
        end else if (acc && dec_face && cnt_q[cnt_idx] != CNT_MAX) begin
            cnt_q[cnt_idx] <= cnt_q[cnt_idx] + CNT_W'(1);
        end
    end

    always_comb begin
        hist_count = '0;
        if (hist_sel >= 3'd1 && hist_sel <= 3'd6) begin
            hist_count = cnt_q[hist_sel - 3'd1];
        end
    end
`else
    logic unused_hist_sel;

    assign unused_hist_sel = ^hist_sel;
    assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_saikoro_reader.sv
// Directed bench for saikoro_reader: debounce latency, glitch rejection,
// illegal patterns, overflow, pop+load, reset abort, fast variant histogram.
module tb_saikoro_reader;
    import saikoro_pkg::*;

`ifdef SAIKORO_READER_HIST_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] lamp = '0;
    logic [6:0] lamp2 = '0;
    logic [2:0] hist_sel = '0;
    logic       err, ovf, err2, ovf2;
    logic [7:0] hist;
    logic [1:0] hist2;
    int         n_pass = 0;
    int         n_chk = 0;

    saikoro_reader_if u_if ();
    saikoro_reader_if u_if2 ();

    saikoro_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .ck         (ck),
        .reset      (reset),
        .lamp       (lamp),
        .out_if     (u_if),
        .err        (err),
        .ovf        (ovf),
        .hist_sel   (hist_sel),
        .hist_count (hist)
    );

    saikoro_reader #(.STABLE_CYCLES(1), .CNT_W(2)) dut2 (
        .ck         (ck),
        .reset      (reset),
        .lamp       (lamp2),
        .out_if     (u_if2),
        .err        (err2),
        .ovf        (ovf2),
        .hist_sel   (hist_sel),
        .hist_count (hist2)
    );

    always #5 ck = ~ck;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        lamp = LAMP_BLANK;
        lamp2 = LAMP_BLANK;
        u_if.out_ready = 1'b1;
        u_if2.out_ready = 1'b1;
        hist_sel = 3'd4;
        tick(2);
        reset = 1'b0;
        n_chk++;
        if (u_if.out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", u_if.out_valid);
        else n_pass++;
        n_chk++;
        if (u_if.out_value !== 3'd0) $display("FAIL rst_value got %0d want 0", u_if.out_value);
        else n_pass++;
        n_chk++;
        if (err !== 1'b0 || ovf !== 1'b0) $display("FAIL rst_err_ovf got %b%b want 00", err, ovf);
        else n_pass++;
        n_chk++;
        if (hist !== 8'd0) $display("FAIL rst_hist got %0d want 0", hist);
        else n_pass++;
    endtask

    task automatic test_accept;
        logic exp_v;
        lamp = LAMP_F4;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            exp_v = (i == 4);
            n_chk++;
            if (u_if.out_valid !== exp_v || err !== 1'b0)
                $display("FAIL acc_valid_e%0d got v=%b e=%b want v=%b e=0", i, u_if.out_valid, err, exp_v);
            else n_pass++;
            if (i == 4) begin
                n_chk++;
                if (u_if.out_value !== 3'd4) $display("FAIL acc_value got %0d want 4", u_if.out_value);
                else n_pass++;
            end
        end
        hist_sel = 3'd4;
        #1;
        n_chk++;
        if (hist !== (HIST ? 8'd1 : 8'd0)) $display("FAIL acc_hist4 got %0d want %0d", hist, HIST ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_glitch;
        int bad = 0;
        int nv = 0;
        int badv = 0;
        for (int i = 0; i < 10; i++) begin
            lamp = (i % 2 == 1) ? LAMP_F6 : LAMP_F5;
            tick(1);
            if (u_if.out_valid || err) bad++;
            tick(1);
            if (u_if.out_valid || err) bad++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL glitch_quiet got %0d events want 0", bad);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (u_if.out_valid) begin
                nv++;
                if (u_if.out_value !== 3'd6) badv++;
            end
        end
        n_chk++;
        if (nv !== 1 || badv !== 0) $display("FAIL glitch_face6 got %0d valids %0d bad want 1 0", nv, badv);
        else n_pass++;
    endtask

    task automatic test_illegal;
        int ne = 0;
        int nv = 0;
        lamp = 7'b0110000;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (err) ne++;
            if (u_if.out_valid) nv++;
        end
        n_chk++;
        if (ne !== 1 || nv !== 0) $display("FAIL illegal_err got err=%0d valid=%0d want 1 0", ne, nv);
        else n_pass++;
        hist_sel = 3'd6;
        #1;
        n_chk++;
        if (hist !== (HIST ? 8'd1 : 8'd0)) $display("FAIL illegal_hist6 got %0d want %0d", hist, HIST ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_ovf;
        u_if.out_ready = 1'b0;
        lamp = LAMP_F2;
        tick(6);
        n_chk++;
        if (u_if.out_valid !== 1'b1 || ovf !== 1'b0)
            $display("FAIL ovf_first got v=%b o=%b want v=1 o=0", u_if.out_valid, ovf);
        else n_pass++;
        lamp = LAMP_BLANK;
        tick(6);
        lamp = LAMP_F3;
        tick(6);
        n_chk++;
        if (u_if.out_valid !== 1'b1 || u_if.out_value !== 3'd2 || ovf !== 1'b1)
            $display("FAIL ovf_drop got v=%b val=%0d o=%b want 1 2 1", u_if.out_valid, u_if.out_value, ovf);
        else n_pass++;
        u_if.out_ready = 1'b1;
        tick(1);
        n_chk++;
        if (u_if.out_valid !== 1'b0) $display("FAIL ovf_drain got %b want 0", u_if.out_valid);
        else n_pass++;
        hist_sel = 3'd2;
        #1;
        n_chk++;
        if (hist !== (HIST ? 8'd1 : 8'd0)) $display("FAIL ovf_hist2 got %0d want %0d", hist, HIST ? 1 : 0);
        else n_pass++;
        hist_sel = 3'd3;
        #1;
        n_chk++;
        if (hist !== (HIST ? 8'd1 : 8'd0)) $display("FAIL ovf_hist3 got %0d want %0d", hist, HIST ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_pop_load;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        u_if.out_ready = 1'b0;
        lamp = LAMP_F1;
        tick(6);
        lamp = LAMP_F5;
        tick(4);
        n_chk++;
        if (u_if.out_valid !== 1'b1 || u_if.out_value !== 3'd1)
            $display("FAIL pl_hold got v=%b val=%0d want 1 1", u_if.out_valid, u_if.out_value);
        else n_pass++;
        u_if.out_ready = 1'b1;
        tick(1);
        n_chk++;
        if (u_if.out_valid !== 1'b1 || u_if.out_value !== 3'd5 || ovf !== 1'b0)
            $display("FAIL pl_swap got v=%b val=%0d o=%b want 1 5 0", u_if.out_valid, u_if.out_value, ovf);
        else n_pass++;
        tick(1);
        n_chk++;
        if (u_if.out_valid !== 1'b0) $display("FAIL pl_drain got %b want 0", u_if.out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic exp_v;
        u_if.out_ready = 1'b1;
        lamp = LAMP_F1;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            exp_v = (i == 4);
            n_chk++;
            if (u_if.out_valid !== exp_v)
                $display("FAIL rmid_valid_r%0d got %b want %b", i, u_if.out_valid, exp_v);
            else n_pass++;
            if (i == 4) begin
                n_chk++;
                if (u_if.out_value !== 3'd1) $display("FAIL rmid_value got %0d want 1", u_if.out_value);
                else n_pass++;
            end
        end
        hist_sel = 3'd1;
        #1;
        n_chk++;
        if (hist !== (HIST ? 8'd1 : 8'd0)) $display("FAIL rmid_hist1 got %0d want %0d", hist, HIST ? 1 : 0);
        else n_pass++;
        hist_sel = 3'd0;
        #1;
        n_chk++;
        if (hist !== 8'd0) $display("FAIL hist_sel0 got %0d want 0", hist);
        else n_pass++;
        hist_sel = 3'd7;
        #1;
        n_chk++;
        if (hist !== 8'd0) $display("FAIL hist_sel7 got %0d want 0", hist);
        else n_pass++;
    endtask

    task automatic test_stable1;
        lamp2 = LAMP_F1;
        tick(1);
        n_chk++;
        if (u_if2.out_valid !== 1'b0) $display("FAIL s1_early got %b want 0", u_if2.out_valid);
        else n_pass++;
        tick(1);
        n_chk++;
        if (u_if2.out_valid !== 1'b1 || u_if2.out_value !== 3'd1)
            $display("FAIL s1_accept got v=%b val=%0d want 1 1", u_if2.out_valid, u_if2.out_value);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            lamp2 = LAMP_BLANK;
            tick(3);
            lamp2 = LAMP_F1;
            tick(3);
        end
        hist_sel = 3'd1;
        #1;
        n_chk++;
        if (hist2 !== (HIST ? 2'd3 : 2'd0) || ovf2 !== 1'b0 || err2 !== 1'b0)
            $display("FAIL s1_sat got h=%0d o=%b e=%b want %0d 0 0", hist2, ovf2, err2, HIST ? 3 : 0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_accept();
        test_glitch();
        test_illegal();
        test_ovf();
        test_pop_load();
        test_reset_mid();
        test_stable1();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
